// File: rtl/tdc_chain_reader.sv
// Carry-chain TDC controller: clears the tap latches, launches an edge, snapshots the thermometer code
// and returns its ones-count on a valid/ready port. Optional bubble detection: TDC_CHAIN_READER_BUBBLE_DETECT_EN.
module tdc_chain_reader #(
    parameter int unsigned N_TAPS        = 64,
    parameter int unsigned LANES         = 8,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CW            = $clog2(N_TAPS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              chain_launch,
    output logic              latch_enable,
    output logic              latch_reset,
    input  logic [N_TAPS-1:0] taps,
    output logic [CW-1:0]     result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overflow,
    output logic              underflow,
    output logic              bubble
);

    localparam int unsigned SCAN_CYCLES = N_TAPS / LANES;
    localparam int unsigned SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned KW          = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_SNAP,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SW-1:0]     settle_cnt;
    logic [KW-1:0]     scan_cnt;
    logic              settle_last;
    logic              scan_last;

    logic [N_TAPS-1:0] shadow;
    logic [CW-1:0]     acc;
    logic [LANES-1:0]  lane_c;
    logic [CW-1:0]     sum_c;

    logic              busy_nxt;
    logic              launch_nxt;
    logic              lenable_nxt;
    logic              lreset_nxt;
    logic              valid_nxt;

    function automatic logic [CW-1:0] lane_ones(input logic [LANES-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            n = n + CW'(v[j]);
        end
        return n;
    endfunction

    assign settle_last = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign scan_last   = (scan_cnt == KW'(SCAN_CYCLES - 1));
    assign lane_c      = shadow[LANES-1:0];
    assign sum_c       = acc + lane_ones(lane_c);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; control outputs are decoded from the next state so they register in step with it
    always_comb begin
        state_nxt   = state;
        busy_nxt    = 1'b0;
        launch_nxt  = 1'b0;
        lenable_nxt = 1'b0;
        lreset_nxt  = 1'b0;
        valid_nxt   = 1'b0;

        case (state)
            S_IDLE:  if (start)        state_nxt = S_CLEAR;
            S_CLEAR: if (settle_last)  state_nxt = S_ARM;
            S_ARM:                     state_nxt = S_SNAP;
            S_SNAP:                    state_nxt = S_SCAN;
            S_SCAN:  if (scan_last)    state_nxt = S_DONE;
            S_DONE:  if (result_ready) state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
        endcase

        busy_nxt    = (state_nxt != S_IDLE);
        lreset_nxt  = (state_nxt == S_CLEAR);
        lenable_nxt = (state_nxt == S_ARM);
        launch_nxt  = (state_nxt == S_ARM) || (state_nxt == S_SNAP) ||
                      (state_nxt == S_SCAN) || (state_nxt == S_DONE);
        valid_nxt   = (state_nxt == S_DONE);
    end

    // Registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            chain_launch <= 1'b0;
            latch_enable <= 1'b0;
            latch_reset  <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            busy         <= busy_nxt;
            chain_launch <= launch_nxt;
            latch_enable <= lenable_nxt;
            latch_reset  <= lreset_nxt;
            result_valid <= valid_nxt;
        end
    end

    // Phase counters, parked at zero outside their own state
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            scan_cnt   <= '0;
        end else begin
            settle_cnt <= (state == S_CLEAR) ? settle_cnt + SW'(1) : '0;
            scan_cnt   <= (state == S_SCAN)  ? scan_cnt + KW'(1)   : '0;
        end
    end

    // Snapshot, then consume the shadow one lane per cycle from the chain head upward
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow    <= '0;
            acc       <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (state == S_SNAP) begin
                shadow <= taps;
                acc    <= '0;
            end
            if (state == S_SCAN) begin
                shadow <= shadow >> LANES;
                acc    <= sum_c;
                if (scan_last) begin
                    result    <= sum_c;
                    overflow  <= (sum_c == CW'(N_TAPS));
                    underflow <= (sum_c == '0);
                end
            end
        end
    end

`ifdef TDC_CHAIN_READER_BUBBLE_DETECT_EN
    logic             prev_top;
    logic             bub_acc;
    logic [LANES:0]   lane_ext_c;
    logic             lane_bub_c;

    // prev_top starts at 1 so the chain head bit never flags against a nonexistent neighbour
    assign lane_ext_c = {lane_c, prev_top};
    assign lane_bub_c = |(lane_ext_c[LANES:1] & ~lane_ext_c[LANES-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_top <= 1'b0;
            bub_acc  <= 1'b0;
            bubble   <= 1'b0;
        end else begin
            if (state == S_SNAP) begin
                prev_top <= 1'b1;
                bub_acc  <= 1'b0;
            end
            if (state == S_SCAN) begin
                prev_top <= lane_c[LANES-1];
                bub_acc  <= bub_acc | lane_bub_c;
                if (scan_last) begin
                    bubble <= bub_acc | lane_bub_c;
                end
            end
        end
    end
`else
    assign bubble = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_chain_reader.sv
// Self-checking bench for tdc_chain_reader: default instance plus a small LANES=1 instance,
// checked against a popcount/bubble model derived directly from the tap code.
module tb_tdc_chain_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, chain_launch, latch_enable, latch_reset;
    logic [63:0] taps;
    logic [6:0]  result;
    logic        result_valid, result_ready, overflow, underflow, bubble;

    logic        s_start;
    logic        s_busy, s_chain_launch, s_latch_enable, s_latch_reset;
    logic [7:0]  s_taps;
    logic [3:0]  s_result;
    logic        s_result_valid, s_result_ready, s_overflow, s_underflow, s_bubble;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdc_chain_reader dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .chain_launch(chain_launch), .latch_enable(latch_enable), .latch_reset(latch_reset),
        .taps(taps), .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .overflow(overflow), .underflow(underflow), .bubble(bubble)
    );

    tdc_chain_reader #(.N_TAPS(8), .LANES(1), .SETTLE_CYCLES(1)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy),
        .chain_launch(s_chain_launch), .latch_enable(s_latch_enable), .latch_reset(s_latch_reset),
        .taps(s_taps), .result(s_result), .result_valid(s_result_valid), .result_ready(s_result_ready),
        .overflow(s_overflow), .underflow(s_underflow), .bubble(s_bubble)
    );

    // Reference model: ones-count and rising-edge-above-a-zero search over the whole code
    function automatic int model_count(input logic [63:0] t);
        return $countones(t);
    endfunction

    function automatic logic model_bubble(input logic [63:0] t);
`ifdef TDC_CHAIN_READER_BUBBLE_DETECT_EN
        for (int i = 1; i < 64; i++) begin
            if (t[i] && !t[i-1]) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start in an IDLE cycle (cycle 0) and return the cycle in which result_valid is first seen
    task automatic launch_and_wait(input logic [63:0] t, output int lat);
        taps = t;
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c < 100; c++) begin
            if (result_valid) begin
                lat = c;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; result_ready = 1'b0; taps = '0;
        s_start = 1'b0; s_result_ready = 1'b0; s_taps = '0;
        tick; tick;
        total++;
        if ({busy, chain_launch, latch_enable, latch_reset, result_valid, overflow, underflow, bubble} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, chain_launch, latch_enable, latch_reset, result_valid, overflow, underflow, bubble});
        end
        total++;
        if (result !== 7'd0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
        reset = 1'b0;
        tick;
        total++;
        if (busy !== 1'b0 || s_busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle: busy=%b s_busy=%b want 0 0", busy, s_busy);
        end
    endtask

    task automatic test_defaults;
        logic exp_lr, exp_le, exp_cl, exp_v, exp_b;
        taps = 64'h0000_0000_0000_FFFF;
        result_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            exp_lr = (c >= 1 && c <= 4);
            exp_le = (c == 5);
            exp_cl = (c >= 5 && c <= 15);
            exp_v  = (c == 15);
            exp_b  = (c <= 15);
            total++;
            if ({latch_reset, latch_enable, chain_launch, result_valid, busy} !== {exp_lr, exp_le, exp_cl, exp_v, exp_b}) begin
                bad++;
                $display("FAIL defaults_wave cycle %0d: lr/le/cl/v/busy=%b want %b", c,
                         {latch_reset, latch_enable, chain_launch, result_valid, busy},
                         {exp_lr, exp_le, exp_cl, exp_v, exp_b});
            end
            if (c == 15) begin
                total++;
                if (result !== 7'd16 || overflow !== 1'b0 || underflow !== 1'b0) begin
                    bad++;
                    $display("FAIL defaults_result: got %0d ov=%b un=%b want 16 0 0", result, overflow, underflow);
                end
            end
            tick;
        end
        result_ready = 1'b0;
    endtask

    task automatic test_extremes;
        logic [63:0] vals [2];
        int lat;
        vals[0] = 64'h0;
        vals[1] = '1;
        for (int k = 0; k < 2; k++) begin
            result_ready = 1'b0;
            launch_and_wait(vals[k], lat);
            total++;
            if (lat !== 15) begin bad++; $display("FAIL extreme_latency[%0d]: got %0d want 15", k, lat); end
            total++;
            if (result !== 7'(model_count(vals[k])) || overflow !== (k == 1) || underflow !== (k == 0)) begin
                bad++;
                $display("FAIL extreme_result[%0d]: got %0d ov=%b un=%b want %0d %b %b", k, result,
                         overflow, underflow, model_count(vals[k]), (k == 1), (k == 0));
            end
            result_ready = 1'b1;
            tick;
            result_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int busy_seen;
        taps = 64'h0000_0000_00FF_FFFF;
        result_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = -1;
        for (int c = 10; c < 100; c++) begin
            if (result_valid) begin lat = c; break; end
            tick;
        end
        total++;
        if (lat !== 15) begin bad++; $display("FAIL bp_latency: got %0d want 15", lat); end
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            total++;
            if (result_valid !== 1'b1 || result !== 7'd24 || overflow !== 1'b0 || underflow !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: v=%b res=%0d ov=%b un=%b want 1 24 0 0", k,
                         result_valid, result, overflow, underflow);
            end
            tick;
        end
        result_ready = 1'b1;
        start = 1'b1;
        tick;
        result_ready = 1'b0;
        start = 1'b0;
        total++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || chain_launch !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: v=%b busy=%b cl=%b want 0 0 0", result_valid, busy, chain_launch);
        end
        busy_seen = 0;
        result_ready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (busy || result_valid) busy_seen++;
            tick;
        end
        result_ready = 1'b0;
        total++;
        if (busy_seen !== 0) begin bad++; $display("FAIL bp_no_queue: active cycles %0d want 0", busy_seen); end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [63:0] t;
        taps = 64'h0000_0000_0000_0FFF;
        result_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (8) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++;
        if ({busy, chain_launch, latch_enable, latch_reset, result_valid, overflow, underflow, bubble} !== 8'h00
            || result !== 7'd0) begin
            bad++;
            $display("FAIL reset_mid: ctrl=%b result=%0d want 00000000 0",
                     {busy, chain_launch, latch_enable, latch_reset, result_valid, overflow, underflow, bubble}, result);
        end
        t = {$urandom, $urandom};
        launch_and_wait(t, lat);
        total++;
        if (lat !== 15 || result !== 7'(model_count(t))) begin
            bad++;
            $display("FAIL reset_mid_restart: lat=%0d res=%0d want 15 %0d", lat, result, model_count(t));
        end
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
    endtask

    task automatic test_bubble;
        logic [63:0] vals [2];
        int lat;
        vals[0] = 64'h0000_0000_0000_FF7F;
        vals[1] = 64'h0000_0000_0000_FE7F;
        for (int k = 0; k < 2; k++) begin
            launch_and_wait(vals[k], lat);
            total++;
            if (lat !== 15 || result !== 7'(15 - k) || bubble !== model_bubble(vals[k])) begin
                bad++;
                $display("FAIL bubble[%0d]: lat=%0d res=%0d bub=%b want 15 %0d %b", k, lat, result,
                         bubble, 15 - k, model_bubble(vals[k]));
            end
            result_ready = 1'b1;
            tick;
            result_ready = 1'b0;
        end
    endtask

    task automatic test_random;
        logic [63:0] t;
        int lat, len, hold;
        for (int it = 0; it < 24; it++) begin
            len = $urandom_range(0, 64);
            if ($urandom_range(0, 2) == 0) t = {$urandom, $urandom};
            else if (len == 64) t = '1;
            else t = (64'd1 << len) - 64'd1;
            launch_and_wait(t, lat);
            total++;
            if (lat !== 15 || result !== 7'(model_count(t)) || overflow !== (model_count(t) == 64)
                || underflow !== (model_count(t) == 0) || bubble !== model_bubble(t)) begin
                bad++;
                $display("FAIL random[%0d] taps=%h: lat=%0d res=%0d ov=%b un=%b bub=%b want 15 %0d %b %b %b",
                         it, t, lat, result, overflow, underflow, bubble, model_count(t),
                         (model_count(t) == 64), (model_count(t) == 0), model_bubble(t));
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                tick;
                total++;
                if (result_valid !== 1'b1 || result !== 7'(model_count(t))) begin
                    bad++;
                    $display("FAIL random_hold[%0d]: v=%b res=%0d want 1 %0d", it, result_valid, result, model_count(t));
                end
            end
            result_ready = 1'b1;
            tick;
            result_ready = 1'b0;
            total++;
            if (result_valid !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL random_release[%0d]: v=%b busy=%b want 0 0", it, result_valid, busy);
            end
        end
    endtask

    task automatic test_small;
        logic [7:0] vals [3];
        int lat;
        vals[0] = 8'h07;
        vals[1] = 8'hFF;
        vals[2] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            s_taps = vals[k];
            s_result_ready = 1'b0;
            s_start = 1'b1;
            tick;
            s_start = 1'b0;
            lat = -1;
            for (int c = 1; c < 60; c++) begin
                if (s_result_valid) begin lat = c; break; end
                tick;
            end
            total++;
            if (lat !== 12 || s_result !== 4'($countones(vals[k])) || s_overflow !== (vals[k] == 8'hFF)
                || s_underflow !== (vals[k] == 8'h00)) begin
                bad++;
                $display("FAIL small[%0d]: lat=%0d res=%0d ov=%b un=%b want 12 %0d %b %b", k, lat, s_result,
                         s_overflow, s_underflow, $countones(vals[k]), (vals[k] == 8'hFF), (vals[k] == 8'h00));
            end
            s_result_ready = 1'b1;
            tick;
            s_result_ready = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_defaults;
        test_extremes;
        test_backpressure;
        test_reset_mid;
        test_bubble;
        test_random;
        test_small;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
